cdc_event_detector: RTL and testbench

- Destination-domain stage fed by the 2-flop synchronizer output (the clkB-domain level signal).
- Glitch-filters the synchronized level and produces single-cycle rise/fall pulses.
- Counts accepted edges and presents each event to a consumer through a valid/ack handshake.
- Single clock domain (clkB); no asynchronous paths inside the block.

---
 rtl/cdc_event_detector.sv | 179 +++++++++++++++++
 tb/tb_cdc_event_detector.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_event_detector.sv
// Destination-domain (clkB) event detector: glitch filter, edge pulses, saturating count and a valid/ack event slot.
// Define CDC_EVT_TIMESTAMP_EN to add a free-running timestamp counter and the evt_time port.
module cdc_event_detector #(
    parameter int FILTER_LEN = 3,
    parameter int CNT_W      = 8,
    parameter int TS_W       = 16
) (
    input  logic             clkB,
    input  logic             rstB,
    input  logic             sync_in,
    input  logic             evt_ack,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             evt_valid,
    output logic             evt_type,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_overflow
`ifdef CDC_EVT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  evt_time
`endif
);

    localparam int                FCNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (FILTER_LEN < 1 || TS_W < 1) begin : g_param_check
        $error("cdc_event_detector: FILTER_LEN and TS_W must be at least 1");
    end

    typedef enum logic [1:0] {
        LOW_STABLE,
        FILT_HIGH,
        HIGH_STABLE,
        FILT_LOW
    } state_t;

    state_t            state, state_nx;
    logic [FCNT_W-1:0] fcnt, fcnt_nx;
    logic              rise_acc, fall_acc;
    logic              accept, evt_load, ovf_set;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        rise_acc = 1'b0;
        fall_acc = 1'b0;
        case (state)
            LOW_STABLE: begin
                if (sync_in) begin
                    if (FILTER_LEN == 1) begin
                        state_nx = HIGH_STABLE;
                        rise_acc = 1'b1;
                    end else begin
                        state_nx = FILT_HIGH;
                        fcnt_nx  = FCNT_ONE;
                    end
                end
            end
            FILT_HIGH: begin
                if (!sync_in) begin
                    state_nx = LOW_STABLE;
                    fcnt_nx  = '0;
                end else if (fcnt == FCNT_LAST) begin
                    state_nx = HIGH_STABLE;
                    fcnt_nx  = '0;
                    rise_acc = 1'b1;
                end else begin
                    fcnt_nx = fcnt + FCNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!sync_in) begin
                    if (FILTER_LEN == 1) begin
                        state_nx = LOW_STABLE;
                        fall_acc = 1'b1;
                    end else begin
                        state_nx = FILT_LOW;
                        fcnt_nx  = FCNT_ONE;
                    end
                end
            end
            FILT_LOW: begin
                if (sync_in) begin
                    state_nx = HIGH_STABLE;
                    fcnt_nx  = '0;
                end else if (fcnt == FCNT_LAST) begin
                    state_nx = LOW_STABLE;
                    fcnt_nx  = '0;
                    fall_acc = 1'b1;
                end else begin
                    fcnt_nx = fcnt + FCNT_ONE;
                end
            end
            default: begin
                state_nx = LOW_STABLE;
                fcnt_nx  = '0;
            end
        endcase
    end

    // A new event takes the slot when it is free or being acked this cycle; otherwise it is dropped.
    assign accept   = rise_acc | fall_acc;
    assign evt_load = accept & (~evt_valid | evt_ack);
    assign ovf_set  = accept & evt_valid & ~evt_ack;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clkB) begin
        if (rstB) begin
            state      <= LOW_STABLE;
            fcnt       <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            fcnt       <= fcnt_nx;
            rise_pulse <= rise_acc;
            fall_pulse <= fall_acc;
            if (rise_acc) begin
                level_out <= 1'b1;
            end else if (fall_acc) begin
                level_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge clkB) begin
        if (rstB) begin
            evt_valid    <= 1'b0;
            evt_type     <= 1'b0;
            evt_count    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (evt_load) begin
                evt_valid <= 1'b1;
                evt_type  <= rise_acc;
            end else if (!accept && evt_ack) begin
                evt_valid <= 1'b0;
            end

            // Clear and a coincident edge/overflow combine: the new edge counts, the set wins.
            if (cnt_clr) begin
                evt_count    <= accept ? CNT_ONE : '0;
                evt_overflow <= ovf_set;
            end else begin
                if (accept && evt_count != CNT_MAX) begin
                    evt_count <= evt_count + CNT_ONE;
                end
                if (ovf_set) begin
                    evt_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef CDC_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clkB) begin
        if (rstB) begin
            ts_cnt   <= '0;
            evt_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (evt_load) begin
                evt_time <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdc_event_detector.sv
// Self-checking bench for cdc_event_detector: directed scenarios plus randomized traffic against a run-length model.
// Define CDC_EVT_TIMESTAMP_EN to also exercise the timestamp port.
module tb_cdc_event_detector;

    localparam int FILTER_LEN = 3;
    localparam int CNT_W      = 4;
    localparam int TS_W       = 4;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;
    localparam int TS_MOD     = 1 << TS_W;

    logic             clkB = 1'b0;
    logic             rstB;
    logic             sync_in;
    logic             evt_ack;
    logic             cnt_clr;
    logic             level_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             evt_valid;
    logic             evt_type;
    logic [CNT_W-1:0] evt_count;
    logic             evt_overflow;
`ifdef CDC_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]  evt_time;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: filtered level plus length of the current run of differing samples.
    logic m_level, m_rise, m_fall, m_valid, m_type, m_ovf;
    int   m_run, m_count, m_ts, m_time;

    cdc_event_detector #(
        .FILTER_LEN(FILTER_LEN),
        .CNT_W     (CNT_W),
        .TS_W      (TS_W)
    ) dut (
        .clkB        (clkB),
        .rstB        (rstB),
        .sync_in     (sync_in),
        .evt_ack     (evt_ack),
        .cnt_clr     (cnt_clr),
        .level_out   (level_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .evt_valid   (evt_valid),
        .evt_type    (evt_type),
        .evt_count   (evt_count),
        .evt_overflow(evt_overflow)
`ifdef CDC_EVT_TIMESTAMP_EN
        ,
        .evt_time    (evt_time)
`endif
    );

    always #5 clkB = ~clkB;

    task automatic model_update();
        logic acc_r, acc_f, ev, ovf_set;
        if (rstB) begin
            m_level = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_type = 0; m_ovf = 0;
            m_run = 0; m_count = 0; m_ts = 0; m_time = 0;
        end else begin
            acc_r = 0;
            acc_f = 0;
            if (sync_in !== m_level) begin
                m_run++;
                if (m_run >= FILTER_LEN) begin
                    m_level = sync_in;
                    m_run   = 0;
                    acc_r   = sync_in;
                    acc_f   = !sync_in;
                end
            end else begin
                m_run = 0;
            end
            ev      = acc_r | acc_f;
            ovf_set = ev && m_valid && !evt_ack;
            m_ovf   = cnt_clr ? ovf_set : (m_ovf | ovf_set);
            if (cnt_clr) m_count = ev ? 1 : 0;
            else if (ev && m_count < CNT_SAT) m_count++;
            if (ev && (!m_valid || evt_ack)) begin
                m_valid = 1;
                m_type  = acc_r;
                m_time  = m_ts;
            end else if (!ev && evt_ack) begin
                m_valid = 0;
            end
            m_rise = acc_r;
            m_fall = acc_f;
            m_ts   = (m_ts + 1) % TS_MOD;
        end
    endtask

    // Drive on the falling edge, advance the model at the rising edge, return 1 time unit later.
    task automatic step(input logic s, input logic a, input logic c, input logic r);
        @(negedge clkB);
        sync_in = s;
        evt_ack = a;
        cnt_clr = c;
        rstB    = r;
        @(posedge clkB);
        model_update();
        #1;
    endtask

    task automatic settle(input logic lvl);
        repeat (FILTER_LEN + 1) step(lvl, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({level_out, rise_pulse, fall_pulse, evt_valid, evt_type, evt_overflow, evt_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {level_out, rise_pulse, fall_pulse, evt_valid, evt_type, evt_overflow, evt_count});
        end
        for (int i = 1; i <= 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (level_out !== 1'b0 || rise_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_filtering edge %0d: level=%b rise=%b expected 0 0", i, level_out, rise_pulse);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({level_out, rise_pulse, evt_valid, evt_type} !== 4'b1111 || evt_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL reset_first_rise: lvl/rise/valid/type=%b count=%0d expected 1111 count=1",
                     {level_out, rise_pulse, evt_valid, evt_type}, evt_count);
        end
`ifdef CDC_EVT_TIMESTAMP_EN
        checks++;
        if (evt_time !== TS_W'(2)) begin
            errors++;
            $display("FAIL reset_first_time: got %0d expected 2", evt_time);
        end
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rise_pulse !== 1'b0 || level_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse_width: rise=%b level=%b expected 0 1", rise_pulse, level_out);
        end
    endtask

    task automatic test_glitch();
        logic [CNT_W-1:0] cnt_before;
        settle(1'b0);
        cnt_before = evt_count;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (level_out !== 1'b0 || rise_pulse !== 1'b0 || evt_valid !== 1'b0 || evt_count !== cnt_before) begin
            errors++;
            $display("FAIL glitch_reject: level=%b rise=%b valid=%b count=%0d expected 0 0 0 count=%0d",
                     level_out, rise_pulse, evt_valid, evt_count, cnt_before);
        end
    endtask

    task automatic test_overflow();
        settle(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (FILTER_LEN) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({rise_pulse, evt_valid, evt_type, evt_overflow} !== 4'b1110) begin
            errors++;
            $display("FAIL overflow_first_rise: rise/valid/type/ovf=%b expected 1110",
                     {rise_pulse, evt_valid, evt_type, evt_overflow});
        end
        repeat (FILTER_LEN) step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({fall_pulse, level_out, evt_valid, evt_type, evt_overflow} !== 5'b10111 || evt_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL overflow_drop: fall/lvl/valid/type/ovf=%b count=%0d expected 10111 count=2",
                     {fall_pulse, level_out, evt_valid, evt_type, evt_overflow}, evt_count);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_ack: valid=%b ovf=%b expected 0 1", evt_valid, evt_overflow);
        end
    endtask

    task automatic test_ack_coincide();
        settle(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (FILTER_LEN) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (FILTER_LEN - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({fall_pulse, evt_valid, evt_type, evt_overflow} !== 4'b1100) begin
            errors++;
            $display("FAIL ack_coincide: fall/valid/type/ovf=%b expected 1100",
                     {fall_pulse, evt_valid, evt_type, evt_overflow});
        end
    endtask

    task automatic test_saturation();
        logic lvl;
        settle(1'b0);
        lvl = 1'b0;
        for (int e = 0; e < 20; e++) begin
            lvl = ~lvl;
            repeat (FILTER_LEN) step(lvl, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (evt_count !== CNT_W'(CNT_SAT)) begin
            errors++;
            $display("FAIL saturation: count=%0d expected %0d", evt_count, CNT_SAT);
        end
        step(lvl, 1'b0, 1'b1, 1'b0);
        checks++;
        if (evt_count !== '0 || evt_overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: count=%0d ovf=%b expected 0 0", evt_count, evt_overflow);
        end
        repeat (FILTER_LEN - 1) step(~lvl, 1'b0, 1'b0, 1'b0);
        step(~lvl, 1'b0, 1'b1, 1'b0);
        checks++;
        if (evt_count !== CNT_W'(1) || (rise_pulse | fall_pulse) !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_edge: count=%0d pulse=%b expected count=1 pulse=1",
                     evt_count, rise_pulse | fall_pulse);
        end
    endtask

`ifdef CDC_EVT_TIMESTAMP_EN
    task automatic test_timestamp();
        settle(1'b0);
        for (int i = 0; i < 2 * TS_MOD && m_ts != 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (m_ts != 12) begin
            errors++;
            $display("FAIL ts_align_timeout: counter at %0d expected 12", m_ts);
        end
        repeat (FILTER_LEN) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (evt_time !== TS_W'(14) || evt_valid !== 1'b1 || evt_type !== 1'b1) begin
            errors++;
            $display("FAIL ts_first: time=%0d valid=%b type=%b expected 14 1 1", evt_time, evt_valid, evt_type);
        end
        repeat (FILTER_LEN) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 * TS_MOD && m_ts != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (m_ts != 0) begin
            errors++;
            $display("FAIL ts_wrap_timeout: counter at %0d expected 0", m_ts);
        end
        repeat (FILTER_LEN - 1) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (evt_time !== TS_W'(2) || evt_valid !== 1'b1 || evt_type !== 1'b1) begin
            errors++;
            $display("FAIL ts_wrapped: time=%0d valid=%b type=%b expected 2 1 1", evt_time, evt_valid, evt_type);
        end
    endtask
`endif

    task automatic test_random();
        logic cur, a, c, r;
        logic [CNT_W+5:0] got, exp;
        cur = m_level;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) cur = ~cur;
            a = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(cur, a, c, r);
            got = {level_out, rise_pulse, fall_pulse, evt_valid, evt_type, evt_overflow, evt_count};
            exp = {m_level, m_rise, m_fall, m_valid, m_type, m_ovf, CNT_W'(m_count)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: lvl/rise/fall/valid/type/ovf/count got %b expected %b", i, got, exp);
            end
`ifdef CDC_EVT_TIMESTAMP_EN
            checks++;
            if (evt_time !== TS_W'(m_time)) begin
                errors++;
                $display("FAIL random_time cycle %0d: got %0d expected %0d", i, evt_time, m_time);
            end
`endif
        end
    endtask

    initial begin
        sync_in = 1'b0;
        evt_ack = 1'b0;
        cnt_clr = 1'b0;
        rstB    = 1'b1;
        test_reset();
        test_glitch();
        test_overflow();
        test_ack_coincide();
        test_saturation();
`ifdef CDC_EVT_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
